fetch_queue: RTL

Instruction prefetch queue between a variable-latency instruction memory and the IF/ID boundary of the pipelined RISC-V core. It runs its own fetch PC, holds one outstanding memory request at a time, buffers returned words with their PC and PC+4 in a small FIFO, and presents them to decode with a valid/stall handshake. An EX-stage redirect (taken branch, jal, jalr) flushes the queue and restarts fetch at the target, discarding any in-flight response.

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Bundle of memory-bus, decode-side and redirect signals around the instruction prefetch queue.
// Signal prefixes are seen from the queue: i_ enters it, o_ leaves it.
interface fetch_queue_if;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_stall;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_pc4;

  modport master (
    input  i_redirect, i_redirect_pc, i_stall, i_mem_ack, i_mem_rdata,
    output o_mem_req, o_mem_addr, o_valid, o_inst, o_pc, o_pc4
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_stall, i_mem_ack, i_mem_rdata,
    input  o_mem_req, o_mem_addr, o_valid, o_inst, o_pc, o_pc4
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: one outstanding fetch, DEPTH-entry FIFO of {pc, pc4, inst}, redirect flush.
// Optional macro FQ_BYPASS_EN forwards an ack on an empty queue straight to decode in the ack cycle.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [31:0]        r_fetchPc;
  logic [31:0]        r_reqPc;
  logic [31:0]        r_instMem [DEPTH];
  logic [31:0]        r_pcMem   [DEPTH];
  logic [31:0]        r_pc4Mem  [DEPTH];
  logic [PTR_W-1:0]   r_rdPtr;
  logic [PTR_W-1:0]   r_wrPtr;
  logic [CNT_W-1:0]   r_count;

  logic               w_empty;
  logic               w_issue;
  logic               w_ackKeep;
  logic               w_bypassTake;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;
  logic [31:0]        w_inst;
  logic [31:0]        w_pc;
  logic [31:0]        w_pc4;

  assign w_empty   = (r_count == '0);
  // A request is only issued when a FIFO slot is free for its word.
  assign w_issue   = (r_state == IDLE) && !bus.i_redirect && (r_count < CNT_W'(DEPTH));
  assign w_ackKeep = (r_state == WAIT) && bus.i_mem_ack && !bus.i_redirect;

`ifdef FQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass     = w_empty && w_ackKeep;
  assign w_bypassTake = w_bypass && !bus.i_stall;
`else
  assign w_bypassTake = 1'b0;
`endif

  assign w_push = w_ackKeep && !w_bypassTake;
  assign w_pop  = !w_empty && !bus.i_stall && !bus.i_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_issue) w_nextState = WAIT;
      WAIT: begin
        if (bus.i_redirect)     w_nextState = bus.i_mem_ack ? IDLE : DROP;
        else if (bus.i_mem_ack) w_nextState = IDLE;
      end
      DROP: if (bus.i_mem_ack) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetchPc <= RESET_PC;
      r_reqPc   <= RESET_PC;
    end else begin
      if (bus.i_redirect)                          r_fetchPc <= bus.i_redirect_pc;
      else if ((r_state == WAIT) && bus.i_mem_ack) r_fetchPc <= r_reqPc + 32'd4;
      if (w_issue) r_reqPc <= r_fetchPc;
    end
  end

  // Redirect flushes the whole queue and overrides any push or pop that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (bus.i_redirect) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instMem[r_wrPtr] <= bus.i_mem_rdata;
      r_pcMem[r_wrPtr]   <= r_reqPc;
      r_pc4Mem[r_wrPtr]  <= r_reqPc + 32'd4;
    end
  end

  always_comb begin
    w_valid = !w_empty;
    w_inst  = w_empty ? NOP   : r_instMem[r_rdPtr];
    w_pc    = w_empty ? '0    : r_pcMem[r_rdPtr];
    w_pc4   = w_empty ? '0    : r_pc4Mem[r_rdPtr];
`ifdef FQ_BYPASS_EN
    if (w_bypass) begin
      w_valid = 1'b1;
      w_inst  = bus.i_mem_rdata;
      w_pc    = r_reqPc;
      w_pc4   = r_reqPc + 32'd4;
    end
`endif
  end

  assign bus.o_mem_req  = (r_state != IDLE);
  assign bus.o_mem_addr = r_reqPc;
  assign bus.o_valid    = w_valid;
  assign bus.o_inst     = w_inst;
  assign bus.o_pc       = w_pc;
  assign bus.o_pc4      = w_pc4;
endmodule
